sysid_checker: RTL

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID (word 0) and build timestamp (word 1)
// over an Avalon-MM master port and compares both against the expected
// values. All outputs are registered and results are sticky.
// With a zero-wait slave, start in cycle N gives a done pulse in cycle N+3.
// While waitrequest is high, address and read are held stable. An optional
// timeout (TIMEOUT_CYCLES stalled cycles per read) ends a stuck sequence.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               single-cycle request, accepted only when idle
//   address, read       Avalon-MM master word address and read strobe
//   readdata            Avalon-MM read data, valid when read & ~waitrequest
//   waitrequest         slave stall
//   busy, done          sequence in progress / one-cycle end pulse
//   id_value, ts_value  last captured ID and timestamp words
//   id_ok, ts_ok        per-word match flags
//   pass, timeout       overall result / sequence ended by timeout
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1417883347,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout
);

  // Counter holds stalled cycles of the current read; it never has to
  // represent more than TIMEOUT_CYCLES.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0] LIMIT  = TIMEOUT_CYCLES[CNT_W:0];
  localparam logic [CNT_W:0] ONE    = {{CNT_W{1'b0}}, 1'b1};
  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               address_q, address_d;
  logic               read_q, read_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        id_value_q, id_value_d;
  logic [31:0]        ts_value_q, ts_value_d;
  logic               id_ok_q, id_ok_d;
  logic               ts_ok_q, ts_ok_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CNT_W:0]     cnt_inc;
  logic               limit_hit;
  logic               id_match;
  logic               ts_match;

  always_comb begin
    // One extra bit so the compare against the limit cannot wrap.
    cnt_inc   = {1'b0, cnt_q} + ONE;
    // Only a stalled cycle can time out: an accepted transfer in the same
    // cycle the count would reach the limit still counts as accepted.
    limit_hit = TO_EN && waitrequest && (cnt_inc == LIMIT);
    id_match  = (readdata == EXPECTED_ID);
    ts_match  = (readdata == EXPECTED_TIMESTAMP);

    state_d    = state_q;
    address_d  = address_q;
    read_d     = read_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          read_d    = 1'b1;
          address_d = 1'b0;
          busy_d    = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end

      RD_ID: begin
        if (!waitrequest) begin
          id_value_d = readdata;
          id_ok_d    = id_match;
          cnt_d      = '0;
          state_d    = RD_TS;
          address_d  = 1'b1;
          read_d     = 1'b1;
        end else if (limit_hit) begin
          // Neither word was read: both flags stay false.
          state_d   = DONE;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          pass_d    = 1'b0;
          read_d    = 1'b0;
          address_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      RD_TS: begin
        if (!waitrequest) begin
          ts_value_d = readdata;
          ts_ok_d    = ts_match;
          // Result is published together with the done pulse.
          pass_d     = id_ok_q & ts_match;
          cnt_d      = '0;
          state_d    = DONE;
          read_d     = 1'b0;
          address_d  = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (limit_hit) begin
          // The ID read already finished, so its flag is kept.
          state_d   = DONE;
          timeout_d = 1'b1;
          ts_ok_d   = 1'b0;
          pass_d    = 1'b0;
          read_d    = 1'b0;
          address_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      DONE: begin
        // done_q is high for exactly this cycle; start is ignored here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      address_q  <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign address  = address_q;
  assign read     = read_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;

  // Bus-protocol invariants.
  a_hold_while_stalled: assert property (@(posedge clock) disable iff (reset)
    (read && waitrequest) |=> ((read && $stable(address)) || timeout));
  a_done_single_cycle: assert property (@(posedge clock) disable iff (reset)
    done |=> !done);
  a_read_only_when_busy: assert property (@(posedge clock) disable iff (reset)
    read |-> busy);

endmodule
